// File: rtl/main_addsub_pkg.sv
// Shared constants and types for the modulo-11 add/subtract block.
package main_addsub_pkg;

    // Operand and result width in bits
    localparam int W = 4;

    // Modulus of the arithmetic
    localparam int MOD_M = 11;

    // Width of the signed intermediates.
    // Add spans 0..30 and subtract spans -15..15, so 6 signed bits hold both.
    localparam int IW = 6;

    // Number of compare-and-correct stages in the reducer.
    // Raw values span -15..30, so at most two +/-11 corrections are needed.
    localparam int STEPS = 2;

    // Operation select encoding
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Zero-extend an unsigned operand into a signed intermediate
    function automatic logic signed [IW-1:0] widen(input logic [W-1:0] v);
        return $signed({{(IW-W){1'b0}}, v});
    endfunction

endpackage

// File: rtl/main_addsub_mod_reduce.sv
// Combinational correction of a signed intermediate into the range 0..MOD_M-1
// using a short chain of compare-and-correct stages (no divider).
module mod_reduce
    import main_addsub_pkg::*;
(
    input  logic signed [IW-1:0] value,
    output logic        [W-1:0]  result
);

    localparam logic signed [IW-1:0] MOD_S = IW'(MOD_M);

    // stage[0] is the raw value; each later stage is one correction step
    logic signed [IW-1:0] stage [0:STEPS];
    logic signed [IW-1:0] final_value;

    assign stage[0] = value;

    // Each stage pulls the value one modulus closer to 0..MOD_M-1:
    // negative values gain MOD_M, values at or above MOD_M lose MOD_M.
    // Once in range a stage passes the value through unchanged.
    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
            assign stage[gi+1] = stage[gi][IW-1]     ? stage[gi] + MOD_S :
                                 (stage[gi] >= MOD_S) ? stage[gi] - MOD_S :
                                                        stage[gi];
        end
    endgenerate

    assign final_value = stage[STEPS];

    // Final value is within 0..MOD_M-1, so the low W bits carry it exactly
    assign result = W'(final_value);

endmodule

// File: rtl/main_addsub.sv
// Modulo-11 adder/subtractor on 4-bit unsigned operands with a registered
// result (latency 1, one operation per cycle, no handshake).
module main_addsub
    import main_addsub_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic x3,
    input  logic x2,
    input  logic x1,
    input  logic x0,
    input  logic y3,
    input  logic y2,
    input  logic y1,
    input  logic y0,
    output logic z3,
    output logic z2,
    output logic z1,
    output logic z0
);

    op_e                  op;
    logic        [W-1:0]  x_vec;
    logic        [W-1:0]  y_vec;
    logic signed [IW-1:0] x_ext;
    logic signed [IW-1:0] y_ext;
    logic signed [IW-1:0] raw_value;
    logic        [W-1:0]  z_next;
    logic        [W-1:0]  z_reg;

    // Gather the individual operand bits into vectors, MSB first.
    // Operands 11..15 are used at full value; the reducer handles them.
    assign op    = op_e'(s);
    assign x_vec = {x3, x2, x1, x0};
    assign y_vec = {y3, y2, y1, y0};
    assign x_ext = widen(x_vec);
    assign y_ext = widen(y_vec);

    // Raw signed sum or difference before modular correction
    always_comb begin
        raw_value = x_ext + y_ext;
        if (op == OP_SUB) begin
            raw_value = x_ext - y_ext;
        end
    end

    mod_reduce u_mod_reduce (
        .value  (raw_value),
        .result (z_next)
    );

    // Output register; reset wins over the inputs sampled in that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            z_reg <= '0;
        end else begin
            z_reg <= z_next;
        end
    end

    assign z3 = z_reg[3];
    assign z2 = z_reg[2];
    assign z1 = z_reg[1];
    assign z0 = z_reg[0];

endmodule

// File: tb/tb_main_addsub.sv
// Directed self-checking bench for main_addsub.
module tb_main_addsub;

    logic clk = 1'b0;
    logic rst;
    logic s;
    logic x3, x2, x1, x0;
    logic y3, y2, y1, y0;
    logic z3, z2, z1, z0;

    int checks = 0;
    int errors = 0;

    main_addsub dut (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .x3  (x3),
        .x2  (x2),
        .x1  (x1),
        .x0  (x0),
        .y3  (y3),
        .y2  (y2),
        .y1  (y1),
        .y0  (y0),
        .z3  (z3),
        .z2  (z2),
        .z1  (z1),
        .z0  (z0)
    );

    always #5 clk = ~clk;

    // Apply one operation on the individual input bits
    task automatic set_inputs(input logic op, input logic [3:0] xv, input logic [3:0] yv);
        s = op;
        {x3, x2, x1, x0} = xv;
        {y3, y2, y1, y0} = yv;
    endtask

    // Advance one rising edge and sample 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the registered result against the expected value
    task automatic check(input string tag, input logic [3:0] expected);
        logic [3:0] observed;
        observed = {z3, z2, z1, z0};
        checks++;
        assert (observed === expected)
            $display("PASS %s z=%0d", tag, observed);
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // True non-negative modulo-11 reference
    function automatic logic [3:0] ref_mod(input logic op, input int xv, input int yv);
        int r;
        r = op ? (xv - yv) : (xv + yv);
        r = ((r % 11) + 11) % 11;
        return 4'(r);
    endfunction

    initial begin
        rst = 1'b1;
        set_inputs(1'b0, 4'd7, 4'd7);

        // Reset loads zero and ignores the inputs present
        step();
        check("reset", 4'd0);
        step();
        check("reset_hold", 4'd0);

        rst = 1'b0;
        set_inputs(1'b0, 4'd1, 4'd1);
        step();
        check("add_1_1", 4'd2);

        // Back-to-back operations
        set_inputs(1'b0, 4'd10, 4'd10);
        step();
        check("add_10_10", 4'd9);
        set_inputs(1'b1, 4'd10, 4'd10);
        step();
        check("sub_10_10", 4'd0);

        set_inputs(1'b1, 4'd3, 4'd7);
        step();
        check("sub_3_7", 4'd7);
        set_inputs(1'b1, 4'd0, 4'd10);
        step();
        check("sub_0_10", 4'd1);

        // Out-of-range operands used at full value
        set_inputs(1'b0, 4'd15, 4'd0);
        step();
        check("add_15_0", 4'd4);
        set_inputs(1'b1, 4'd0, 4'd15);
        step();
        check("sub_0_15", 4'd7);
        set_inputs(1'b0, 4'd15, 4'd15);
        step();
        check("add_15_15", 4'd8);
        set_inputs(1'b1, 4'd15, 4'd0);
        step();
        check("sub_15_0", 4'd4);
        set_inputs(1'b1, 4'd4, 4'd15);
        step();
        check("sub_4_15", 4'd0);

        // Mid-stream reset with inputs held
        set_inputs(1'b0, 4'd5, 4'd4);
        step();
        check("add_5_4", 4'd9);
        rst = 1'b1;
        step();
        check("mid_reset", 4'd0);
        rst = 1'b0;
        step();
        check("after_reset", 4'd9);

        // Sweep of in-range operands for both operations
        for (int op = 0; op < 2; op++) begin
            for (int xv = 0; xv <= 10; xv++) begin
                for (int yv = 0; yv <= 10; yv++) begin
                    set_inputs(op[0], 4'(xv), 4'(yv));
                    step();
                    check($sformatf("sweep_s%0d_x%0d_y%0d", op, xv, yv),
                          ref_mod(op[0], xv, yv));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
